// File: rtl/skid_pipe_pkg.sv
// Shared definitions for the skid/shift register pipeline.
package skid_pipe_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned DEPTH_DEF = 2;

    // Bits needed to hold an occupancy value in 0..depth (never less than 1).
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        int unsigned bits;
        bits = 1;
        while ((64'd1 << bits) < 64'(depth) + 64'd1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: data register plus valid bit, advanced by the caller.
module pipe_stage
    import skid_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    // Valid bit: cleared by flush, otherwise takes the incoming valid when advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (adv) begin
            valid_q <= in_valid;
        end
    end

    // Data register loads only real words; bubbles leave stale data in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (!flush && adv && in_valid) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/skid_shift_pipeline.sv
// Parametrised valid/ready register pipeline with bubble collapsing, flush,
// occupancy count and a debug tap bus exposing every stage.
module skid_shift_pipeline
    import skid_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = clog2_cnt(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       count,
    output logic [WIDTH*DEPTH-1:0] taps
);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // A stage advances when downstream drains or any stage at or after it is empty.
    // Written flat rather than as a recursive chain so no signal feeds itself.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            adv[k] = out_ready;
            for (int unsigned j = k; j < DEPTH; j++) begin
                if (!stage_valid[j]) begin
                    adv[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_in_data;
        logic             stage_in_valid;

        if (k == 0) begin : g_head
            assign stage_in_data  = in_data;
            assign stage_in_valid = in_valid;
        end else begin : g_body
            assign stage_in_data  = stage_data[k-1];
            assign stage_in_valid = stage_valid[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .adv      (adv[k]),
            .in_data  (stage_in_data),
            .in_valid (stage_in_valid),
            .data_q   (stage_data[k]),
            .valid_q  (stage_valid[k])
        );

        assign taps[k*WIDTH +: WIDTH] = stage_data[k];
    end

    // Occupancy as an up/down counter; tracks the popcount of stage_valid.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
